// File: rtl/avalon_st_packet_arbiter_if.sv
// avalon_st_if: Avalon-ST stream bundle, ready-latency 0.
// master drives the beat fields, slave returns rdy.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  localparam int DW = DATA_WIDTH_IN_BYTES * 8,
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ?
                      $clog2(DATA_WIDTH_IN_BYTES) : 1
);
  logic          valid;
  logic          sop;
  logic          eop;
  logic [DW-1:0] data;
  logic [EW-1:0] empty;
  logic          rdy;

  modport master (
    output valid, sop, eop, data, empty,
    input  rdy
  );

  modport slave (
    input  valid, sop, eop, data, empty,
    output rdy
  );
endinterface

// File: rtl/avalon_st_packet_arbiter.sv
// avalon_st_packet_arbiter: round-robin, packet-locked merge of
// NUM_SOURCES Avalon-ST sources onto one zero-latency output stream.
module avalon_st_packet_arbiter #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int NUM_SOURCES = 4,
  localparam int DW = DATA_WIDTH_IN_BYTES * 8,
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ?
                      $clog2(DATA_WIDTH_IN_BYTES) : 1,
  localparam int SW = $clog2(NUM_SOURCES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SOURCES-1:0]    in_valid,
  input  logic [NUM_SOURCES-1:0]    in_sop,
  input  logic [NUM_SOURCES-1:0]    in_eop,
  input  logic [NUM_SOURCES*DW-1:0] in_data,
  input  logic [NUM_SOURCES*EW-1:0] in_empty,
  output logic [NUM_SOURCES-1:0]    in_rdy,
  avalon_st_if.master               arb_msg,
  output logic [NUM_SOURCES-1:0]    grant,
  output logic                      busy
);

  typedef enum logic {IDLE, LOCKED} state_t;
  typedef logic [SW:0] sum_t;

  localparam sum_t NS = sum_t'(NUM_SOURCES);

  state_t        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] rr_q, rr_d;
  logic          gap_q, gap_d;

  logic          found;
  logic [SW-1:0] pick;
  sum_t          sum;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_nxt;
  logic          sel_vld;
  logic          xfer;

  always_comb begin : rr_search
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      sum = {1'b0, rr_q} + sum_t'(k);
      if (sum >= NS) sum = sum - NS;
      if (!found && in_valid[sum[SW-1:0]]) begin
        found = 1'b1;
        pick  = sum[SW-1:0];
      end
    end
  end

  // gap_q holds off arbitration for the cycle after a locked packet ends
  assign sel_vld = !rst &&
                   (state_q == LOCKED || (!gap_q && found));
  assign sel     = (state_q == LOCKED) ? owner_q : pick;
  assign sel_nxt = (sel == SW'(NUM_SOURCES - 1)) ?
                   '0 : sel + SW'(1);
  assign busy    = !rst && (state_q == LOCKED);

  always_comb begin : out_mux
    arb_msg.valid = 1'b0;
    arb_msg.sop   = 1'b0;
    arb_msg.eop   = 1'b0;
    arb_msg.data  = '0;
    arb_msg.empty = '0;
    in_rdy        = '0;
    grant         = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (sel_vld && sel == SW'(i)) begin
        arb_msg.valid = in_valid[i];
        arb_msg.sop   = in_sop[i];
        arb_msg.eop   = in_eop[i];
        arb_msg.data  = in_data[i*DW +: DW];
        arb_msg.empty = in_empty[i*EW +: EW];
        in_rdy[i]     = arb_msg.rdy;
        grant[i]      = 1'b1;
      end
    end
  end

  assign xfer = arb_msg.valid & arb_msg.rdy;

  always_comb begin : fsm
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gap_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          if (xfer && arb_msg.eop) begin
            rr_d = sel_nxt;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && arb_msg.eop) begin
          state_d = IDLE;
          rr_d    = sel_nxt;
          gap_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
    end
  end

endmodule
